// File: rtl/jk_excitation_driver.sv
// Drive side of a JK flip-flop: turns a stream of target Q values into J/K
// excitation pulses, then checks Q feedback and counts mismatches.
module jk_excitation_driver #(
  parameter bit DC_FILL = 1'b0,
  parameter bit RESET_Q = 1'b0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  input  logic             tgt_q,
  output logic             tgt_ready,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             mismatch,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state;
  state_t state_next;
  logic   tgt_r;
  logic   exp_q;
  logic   accept;
  logic   j_exc;
  logic   k_exc;
  logic   q_bad;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = DRIVE;
      DRIVE:   state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tgt_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  assign accept = tgt_valid && tgt_ready;
  assign q_bad  = (q_fb != tgt_r);

  // Toggle style asserts both inputs on any change; set/reset style drives
  // only the input that forces the new value.
  always_comb begin
    if (DC_FILL) begin
      j_exc = exp_q ^ tgt_q;
      k_exc = exp_q ^ tgt_q;
    end else begin
      j_exc = ~exp_q & tgt_q;
      k_exc = exp_q & ~tgt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      j          <= 1'b0;
      k          <= 1'b0;
      tgt_r      <= 1'b0;
      exp_q      <= RESET_Q;
      mismatch   <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
      xfer_count <= '0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tgt_r <= tgt_q;
            j     <= j_exc;
            k     <= k_exc;
          end
        end
        DRIVE: begin
          j <= 1'b0;
          k <= 1'b0;
        end
        CHECK: begin
          xfer_count <= xfer_count + CNT_ONE;
          // On a miss, adopt the observed Q so later excitations start from reality.
          if (q_bad) begin
            mismatch <= 1'b1;
            err      <= 1'b1;
            exp_q    <= q_fb;
            if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
          end else begin
            exp_q <= tgt_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Drive side of a JK flip-flop.
- Accepts a stream of desired next-state bits over a valid/ready handshake and converts each one into a registered J/K excitation pair using the JK excitation table.
- Observes the flip-flop's Q output and checks that the transition took effect, counting mismatches.
- Sits in front of the JK flip-flop blocks (including JK built from SR/D/T) as a self-checking stimulus engine.

Parameters:
- DC_FILL, 0, don't-care resolution. 0: drive don't-cares as 0 (set/reset style). 1: drive don't-cares as 1 on changes (toggle style).
- RESET_Q, 0, expected flip-flop state after reset.
- CNT_W, 8, width of the error and transfer counters.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (reset=0 resets on the next clk rising edge).
- tgt_valid  input  1  desired next-state bit is valid.
- tgt_q  input  1  desired next state of the flip-flop.
- tgt_ready  output  1  block can accept a target this cycle.
- q_fb  input  1  Q output of the driven JK flip-flop.
- j  output  1  registered J excitation.
- k  output  1  registered K excitation.
- busy  output  1  high while in DRIVE or CHECK.
- mismatch  output  1  one-cycle pulse when the checked Q differs from the expected value.
- err  output  1  sticky error flag.
- err_count  output  CNT_W  saturating mismatch count.
- xfer_count  output  CNT_W  wrapping count of completed checks.

Behaviour:
- Reset (reset=0 at a rising edge) forces, regardless of state:
  - state=IDLE
  - j=0, k=0, busy=0, mismatch=0, err=0
  - err_count=0, xfer_count=0
  - exp_q=RESET_Q
  - tgt_ready goes to 1 the cycle after reset releases.
- Reset mid-DRIVE or mid-CHECK abandons the transfer: no mismatch pulse, no count update.
- FSM states: IDLE, DRIVE, CHECK.
- IDLE:
  - tgt_ready=1, j=k=0.
  - On tgt_valid&&tgt_ready: latch tgt_q into tgt_r, register j/k from (exp_q, tgt_q), go to DRIVE.
- DRIVE (exactly 1 cycle):
  - tgt_ready=0, busy=1, j/k held.
  - The flip-flop samples j/k at the closing edge.
  - Next state is CHECK, with j=k=0 registered.
- CHECK (exactly 1 cycle):
  - tgt_ready=0, busy=1, j=k=0 so the flip-flop holds.
  - At the closing edge, q_fb is compared with tgt_r.
  - Equal: exp_q<=tgt_r.
  - Not equal: mismatch pulses high in the following cycle, err<=1, err_count increments (saturating at all-ones), exp_q<=q_fb (resynchronise).
  - xfer_count increments in both cases (wraps).
  - Next state is IDLE.
- Throughput is one target per 3 cycles: accept edge, DRIVE, CHECK; the block returns to IDLE and is ready again.
- tgt_ready is a Moore output (=1 only in IDLE). tgt_valid may be held high continuously.
- tgt_q is sampled only on the accept edge; changes in other cycles are ignored.
- Excitation mapping, written as (exp_q -> tgt_q): J,K.
  - DC_FILL=0:
    - 0->0: 0,0
    - 0->1: 1,0
    - 1->0: 0,1
    - 1->1: 0,0
  - DC_FILL=1:
    - 0->0: 0,0
    - 0->1: 1,1
    - 1->0: 1,1
    - 1->1: 0,0
- j and k never change outside the accept-edge and DRIVE-exit updates.
- Simultaneous events:
  - A mismatch in CHECK coinciding with err_count at all-ones: err_count stays at all-ones, mismatch still pulses.
  - Reset has priority over everything.

Test Plan:
- Reset, DC_FILL=0: apply reset=0 for 2 cycles, release -> j=k=0, tgt_ready=1, err=0, err_count=0, xfer_count=0, exp_q=0.
- DC_FILL=0, flip-flop model connected, targets 1,1,0,0:
  - j/k in DRIVE cycles are 10, 00, 01, 00.
  - q_fb ends at 0, no mismatch, xfer_count=4.
- DC_FILL=1, targets 1,0,1:
  - j/k in DRIVE cycles are 11, 11, 11 (toggle).
  - q_fb follows 1,0,1, err=0.
- Fault injection: tie q_fb=0, send target 1 ->
  - mismatch pulses once, err=1, err_count=1.
  - exp_q resyncs to 0; the next target 1 drives j=1,k=0 again.
- Handshake: hold tgt_valid=1 and change tgt_q every cycle ->
  - an accept occurs only every 3rd cycle, tgt_ready=0 during DRIVE/CHECK.
  - The latched values equal tgt_q on the accept edges only.
- Reset mid-DRIVE with target 1:
  - next cycle is IDLE with j=k=0.
  - No mismatch pulse, xfer_count=0.
- Saturation, CNT_W=2, q_fb forced to mismatch on 5 transfers ->
  - err_count=3, xfer_count=1 (wrapped), mismatch pulses 5 times.
